tick_share_sched: RTL and testbench

Programmable tick generator and round-robin scheduler that shares one periodic clock-enable resource among four requesters. It produces a one-cycle `tick` every `cur_div` clock cycles, the same role as the fixed divide-by-six `clk_flag`, and awards each tick to exactly one pending requester. The divide ratio is reconfigurable at runtime, and a new ratio takes effect only on a period boundary. It sits between the slow-rate consumers (LED/UART/scan logic) and the system clock domain.

---
 rtl/tick_share_sched.sv | 115 +++++++++++
 tb/tb_tick_share_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tick_share_sched.sv
// tick_share_sched: programmable tick generator that hands each tick to one of
// four requesters in round-robin order. The divide ratio can be rewritten at
// runtime; a new ratio is held pending and swapped in only on a period
// boundary (or immediately while the scheduler is idle).
module tick_share_sched #(
  parameter int CNT_W       = 8,
  parameter int DIV_DEFAULT = 6
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic [3:0]       req,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             tick,
  output logic [3:0]       grant,
  output logic [CNT_W-1:0] cur_div,
  output logic             cfg_busy,
  output logic             cfg_err
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_curDiv;
  logic [CNT_W-1:0] r_pendDiv;
  logic             r_cfgBusy;
  logic             r_cfgErr;
  logic             r_tick;
  logic [3:0]       r_grant;
  logic [1:0]       r_last;

  logic             w_wrap;
  logic             w_cfgOk;
  logic             w_cfgBad;
  logic             w_apply;
  logic [1:0]       w_sel;
  logic [1:0]       w_idx;
  logic             w_anyReq;

  // Wrap edge is the last count of a period; writes below 2 are rejected.
  // A pending ratio is applied on a wrap edge or on any idle edge.
  assign w_wrap   = en && (r_cnt == (r_curDiv - CNT_W'(1)));
  assign w_cfgOk  = cfg_wr && (cfg_div >= CNT_W'(2));
  assign w_cfgBad = cfg_wr && (cfg_div <  CNT_W'(2));
  assign w_apply  = r_cfgBusy && (w_wrap || !en);

  // Round-robin search starting just after the last winner; walking the
  // candidates from farthest to nearest lets the nearest set bit win.
  always_comb begin
    w_sel    = r_last;
    w_idx    = r_last;
    w_anyReq = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      w_idx = r_last + 2'(k);
      if (req[w_idx]) begin
        w_sel    = w_idx;
        w_anyReq = 1'b1;
      end
    end
  end

  // Period counter, tick pulse and registered one-hot grant.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_grant <= 4'b0000;
      r_last  <= 2'd3;
    end else if (!en) begin
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_grant <= 4'b0000;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
      if (w_anyReq) begin
        r_grant <= 4'b0001 << w_sel;
        r_last  <= w_sel;
      end else begin
        r_grant <= 4'b0000;
      end
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
      r_tick  <= 1'b0;
      r_grant <= 4'b0000;
    end
  end

  // Ratio configuration: an accepted write always lands in the pending slot
  // and sets busy, even on the edge that applies the previous pending value.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_curDiv  <= CNT_W'(DIV_DEFAULT);
      r_pendDiv <= CNT_W'(DIV_DEFAULT);
      r_cfgBusy <= 1'b0;
      r_cfgErr  <= 1'b0;
    end else begin
      r_cfgErr <= w_cfgBad;
      if (w_apply) begin
        r_curDiv  <= r_pendDiv;
        r_cfgBusy <= 1'b0;
      end
      if (w_cfgOk) begin
        r_pendDiv <= cfg_div;
        r_cfgBusy <= 1'b1;
      end
    end
  end

  assign tick     = r_tick;
  assign grant    = r_grant;
  assign cur_div  = r_curDiv;
  assign cfg_busy = r_cfgBusy;
  assign cfg_err  = r_cfgErr;

endmodule

// File: tb/tb_tick_share_sched.sv
// Directed testbench for tick_share_sched: default rate, round robin, sparse
// requests, reconfiguration corner cases, idle apply and mid-period reset.
module tb_tick_share_sched;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       en;
  logic [3:0] req;
  logic       cfg_wr;
  logic [7:0] cfg_div;
  logic       tick;
  logic [3:0] grant;
  logic [7:0] cur_div;
  logic       cfg_busy;
  logic       cfg_err;

  int testsRun    = 0;
  int testsFailed = 0;

  tick_share_sched #(.CNT_W(8), .DIV_DEFAULT(6)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (en),
    .req       (req),
    .cfg_wr    (cfg_wr),
    .cfg_div   (cfg_div),
    .tick      (tick),
    .grant     (grant),
    .cur_div   (cur_div),
    .cfg_busy  (cfg_busy),
    .cfg_err   (cfg_err)
  );

  // 10 ns system clock.
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, ending 1 ns after the last one.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // One-cycle configuration write (consumes one edge).
  task automatic cfgWrite(input int val);
    cfg_wr  = 1'b1;
    cfg_div = 8'(val);
    applyStimulus(1);
    cfg_wr  = 1'b0;
  endtask

  // Edges until tick is seen high, bounded so a dead DUT cannot hang the run.
  task automatic waitTick(output int n);
    n = 0;
    do begin
      @(posedge sys_clk);
      #1;
      n++;
    end while (!tick && n < 300);
    if (!tick) checkOutput("tickTimeout", int'(tick), 1);
  endtask

  initial begin
    int n;
    logic [3:0] sparseExp [3];
    sparseExp[0] = 4'b0010;
    sparseExp[1] = 4'b1000;
    sparseExp[2] = 4'b0010;

    sys_rst_n = 1'b1;
    en        = 1'b0;
    req       = 4'b0000;
    cfg_wr    = 1'b0;
    cfg_div   = 8'd0;
    #3 sys_rst_n = 1'b0;
    #1;

    // Reset values
    checkOutput("rstTick",  int'(tick),     0);
    checkOutput("rstGrant", int'(grant),    0);
    checkOutput("rstDiv",   int'(cur_div),  6);
    checkOutput("rstBusy",  int'(cfg_busy), 0);
    checkOutput("rstErr",   int'(cfg_err),  0);

    // Default rate: tick after edges 6 and 12, no grants without requests
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    en        = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      applyStimulus(1);
      checkOutput($sformatf("defTick%0d", e), int'(tick), (e == 6 || e == 12) ? 1 : 0);
      checkOutput($sformatf("defGrant%0d", e), int'(grant), 0);
    end

    // Round robin with all requesters active
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      waitTick(n);
      checkOutput($sformatf("rrPeriod%0d", k), n, 6);
      checkOutput($sformatf("rrGrant%0d", k), int'(grant), 1 << (k % 4));
    end
    applyStimulus(1);
    checkOutput("grantDrops", int'(grant), 0);
    checkOutput("tickDrops",  int'(tick),  0);

    // Sparse requests from last=3
    req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      waitTick(n);
      checkOutput($sformatf("sparseGrant%0d", k), int'(grant), int'(sparseExp[k]));
    end
    req = 4'b0000;
    waitTick(n);
    checkOutput("noReqTick",  int'(tick),  1);
    checkOutput("noReqGrant", int'(grant), 0);
    req = 4'b1111;
    waitTick(n);
    checkOutput("ptrHeldGrant", int'(grant), 4'b0100);
    req = 4'b0000;

    // Reconfigure to 3 mid-period
    applyStimulus(2);
    cfgWrite(3);
    checkOutput("cfgBusySet", int'(cfg_busy), 1);
    checkOutput("cfgDivOld",  int'(cur_div),  6);
    waitTick(n);
    checkOutput("cfgOldPeriod", n + 3, 6);
    checkOutput("cfgBusyClr",   int'(cfg_busy), 0);
    checkOutput("cfgDivNew",    int'(cur_div),  3);
    waitTick(n);
    checkOutput("div3Period0", n, 3);
    waitTick(n);
    checkOutput("div3Period1", n, 3);

    // Rejected write of 1
    cfgWrite(1);
    checkOutput("errPulse",  int'(cfg_err),  1);
    checkOutput("errNoBusy", int'(cfg_busy), 0);
    applyStimulus(1);
    checkOutput("errClear",  int'(cfg_err),  0);
    waitTick(n);
    checkOutput("errPeriod", n + 2, 3);
    checkOutput("errDiv",    int'(cur_div), 3);

    // Write on the wrap edge itself
    applyStimulus(2);
    cfgWrite(9);
    checkOutput("wrapWrTick", int'(tick),     1);
    checkOutput("wrapWrDiv",  int'(cur_div),  3);
    checkOutput("wrapWrBusy", int'(cfg_busy), 1);
    waitTick(n);
    checkOutput("wrapWrOldPeriod", n, 3);
    checkOutput("wrapWrDivNew",    int'(cur_div), 9);
    waitTick(n);
    checkOutput("div9Period", n, 9);

    // Two writes in one period: last one wins
    applyStimulus(1);
    cfgWrite(4);
    cfgWrite(5);
    checkOutput("lastWinsBusy", int'(cfg_busy), 1);
    waitTick(n);
    checkOutput("lastWinsOldPeriod", n + 3, 9);
    checkOutput("lastWinsDiv",       int'(cur_div), 5);
    waitTick(n);
    checkOutput("div5Period", n, 5);

    // Idle with a ratio pending: applies at once, no tick
    cfgWrite(7);
    en = 1'b0;
    applyStimulus(1);
    checkOutput("idleDiv",  int'(cur_div),  7);
    checkOutput("idleBusy", int'(cfg_busy), 0);
    checkOutput("idleTick", int'(tick),     0);
    req = 4'b0010;
    for (int e = 0; e < 3; e++) begin
      applyStimulus(1);
      checkOutput($sformatf("idleNoTick%0d", e), int'(tick), 0);
      checkOutput($sformatf("idleNoGrant%0d", e), int'(grant), 0);
    end
    en = 1'b1;
    waitTick(n);
    checkOutput("resumePeriod", n, 7);
    checkOutput("resumeGrant",  int'(grant), 4'b0010);

    // Reset with cnt=4, a ratio pending and last=1
    cfgWrite(5);
    applyStimulus(3);
    checkOutput("preRstBusy", int'(cfg_busy), 1);
    req       = 4'b1111;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("midRstTick",  int'(tick),     0);
    checkOutput("midRstGrant", int'(grant),    0);
    checkOutput("midRstDiv",   int'(cur_div),  6);
    checkOutput("midRstBusy",  int'(cfg_busy), 0);
    checkOutput("midRstErr",   int'(cfg_err),  0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    waitTick(n);
    checkOutput("postRstPeriod", n, 6);
    checkOutput("postRstGrant",  int'(grant),   4'b0001);
    checkOutput("postRstDiv",    int'(cur_div), 6);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
